// File: rtl/morse_tx_if.sv
// Handshake and output bundle between the key decoder (master) and morse_tx (slave).
// The repeat_en request exists only when MORSE_REPEAT_EN is defined.
interface morse_tx_if #(
    parameter int MAX_SYMS = 4,
    parameter int LEN_W    = $clog2(MAX_SYMS + 1)
);
    logic                start;
    logic [LEN_W-1:0]    sym_len;
    logic [MAX_SYMS-1:0] sym_pattern;
`ifdef MORSE_REPEAT_EN
    logic                repeat_en;
`endif
    logic                outs;
    logic                ready;
    logic                busy;
    logic                done;

    modport master (
        output start, sym_len, sym_pattern,
`ifdef MORSE_REPEAT_EN
        output repeat_en,
`endif
        input  outs, ready, busy, done
    );

    modport slave (
        input  start, sym_len, sym_pattern,
`ifdef MORSE_REPEAT_EN
        input  repeat_en,
`endif
        output outs, ready, busy, done
    );
endinterface

// File: rtl/morse_tx.sv
// Morse letter transmitter: plays up to MAX_SYMS dots/dashes with unit timing from a tick prescaler.
// Optional MORSE_REPEAT_EN adds a repeat request and a 3-unit letter gap (LGAP) before replay.
module morse_tx #(
    parameter int TICK_DIV   = 25000000,
    parameter int MAX_SYMS   = 4,
    parameter int DOT_UNITS  = 1,
    parameter int DASH_UNITS = 3,
    parameter int GAP_UNITS  = 1,
    parameter int LEN_W      = $clog2(MAX_SYMS + 1)
) (
    input  logic      clk,
    input  logic      resetn,
    morse_tx_if.slave bus
);
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int UM1  = (DOT_UNITS > DASH_UNITS) ? DOT_UNITS : DASH_UNITS;
    localparam int UM2  = (UM1 > GAP_UNITS) ? UM1 : GAP_UNITS;
    localparam int UMAX = (UM2 > 3) ? UM2 : 3;
    localparam int UW   = $clog2(UMAX + 1);
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_SYMS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
`ifdef MORSE_REPEAT_EN
        S_LGAP,
`endif
        S_FIN
    } state_t;

    state_t              r_state;
    logic [TW-1:0]       r_tick;
    logic [UW-1:0]       r_unit;
    logic [LEN_W-1:0]    r_idx;
    logic [LEN_W-1:0]    r_len;
    logic [MAX_SYMS-1:0] r_pat;
    logic                r_outs;
    logic                r_busy;
    logic                r_ready;
    logic                r_done;

    logic                w_strobe;
    logic                w_cur_dash;
    logic                w_phase_end;
    logic                w_last_sym;
    logic [TW-1:0]       w_tick_adv;
    logic [UW-1:0]       w_unit_adv;
    logic [UW-1:0]       w_units;
    logic [MAX_SYMS-1:0] w_pat_sh;
    logic [LEN_W-1:0]    w_idx_nx;
    logic [LEN_W-1:0]    w_len_clamp;

    always_comb begin
        w_strobe    = (r_tick == TICK_LAST);
        w_tick_adv  = w_strobe ? '0 : r_tick + 1'b1;
        w_unit_adv  = w_strobe ? r_unit + 1'b1 : r_unit;
        w_pat_sh    = r_pat >> r_idx;
        w_cur_dash  = w_pat_sh[0];
        case (r_state)
            S_MARK:  w_units = w_cur_dash ? UW'(DASH_UNITS) : UW'(DOT_UNITS);
            S_SPACE: w_units = UW'(GAP_UNITS);
`ifdef MORSE_REPEAT_EN
            S_LGAP:  w_units = UW'(3);
`endif
            default: w_units = UW'(1);
        endcase
        // A phase ends on the strobe that completes its final unit.
        w_phase_end = w_strobe && (r_unit == w_units - 1'b1);
        w_idx_nx    = r_idx + 1'b1;
        w_last_sym  = (w_idx_nx >= r_len);
        w_len_clamp = (bus.sym_len > MAX_L) ? MAX_L : bus.sym_len;
    end

    // Pattern is data only; it is captured on acceptance and never needs a reset value.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.start)
            r_pat <= bus.sym_pattern;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_unit  <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_outs  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_tick <= w_tick_adv;
            r_unit <= w_unit_adv;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tick <= '0;
                    r_unit <= '0;
                    if (bus.start) begin
                        r_len   <= w_len_clamp;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        if (w_len_clamp != '0) begin
                            r_state <= S_MARK;
                            r_outs  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_MARK: begin
                    if (w_phase_end) begin
                        r_tick  <= '0;
                        r_unit  <= '0;
                        r_state <= S_SPACE;
                        r_outs  <= 1'b0;
                    end
                end
                S_SPACE: begin
                    if (w_phase_end) begin
                        r_tick <= '0;
                        r_unit <= '0;
                        r_idx  <= w_idx_nx;
                        if (!w_last_sym) begin
                            r_state <= S_MARK;
                            r_outs  <= 1'b1;
                        end else
`ifdef MORSE_REPEAT_EN
                        if (bus.repeat_en) begin
                            r_state <= S_LGAP;
                            r_idx   <= '0;
                        end else
`endif
                        begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
`ifdef MORSE_REPEAT_EN
                S_LGAP: begin
                    if (w_phase_end) begin
                        r_tick  <= '0;
                        r_unit  <= '0;
                        r_state <= S_MARK;
                        r_outs  <= 1'b1;
                    end else begin
                        // Raise done so it is registered during the final LGAP cycle.
                        r_done <= (w_tick_adv == TICK_LAST) && (w_unit_adv == UW'(2));
                    end
                end
`endif
                S_FIN: begin
                    r_tick  <= '0;
                    r_unit  <= '0;
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_outs  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.outs  = r_outs;
    assign bus.busy  = r_busy;
    assign bus.ready = r_ready;
    assign bus.done  = r_done;
endmodule
